uart_tx_fifo: RTL

- Buffered UART transmitter, downstream of the receive/control path: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them onto UART_TX.
- Derives bit timing directly from sysclk (no separate baud/sample clock domains); whole block runs on sysclk.
- Frames are 8N1 by default, with optional parity and a second stop bit.
- Replaces the unbuffered send path so bursts of received bytes are not lost while a frame is in flight.

---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter. Bytes enter a FIFO over a valid/ready handshake
//   and are serialised onto UART_TX as 8N1 frames, with an optional parity bit
//   and an optional second stop bit. Bit timing is derived from sysclk.
//
// Ports
//   sysclk      in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   TX_DATA     in   byte to enqueue
//   TX_VALID    in   TX_DATA valid this cycle
//   TX_READY    out  FIFO not full
//   UART_TX     out  serial line, idle high (registered)
//   TX_BUSY     out  serialiser not idle (registered)
//   FIFO_COUNT  out  queued entries, excluding the byte being shifted
//
// State table
//   state    | meaning
//   S_IDLE   | line high, waiting for a queued byte
//   S_START  | start bit (low)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (only when PARITY_EN=1)
//   S_STOP   | stop bit(s), high; may pop the next byte on its last cycle
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [7:0]                    TX_DATA,
  input  logic                          TX_VALID,
  output logic                          TX_READY,
  output logic                          UART_TX,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Serialiser
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;     // data bit index in S_DATA, stop bit index in S_STOP
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  state_t        w_state_next;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    w_bit_next;
  logic [7:0]    w_shift_next;
  logic          w_tx_next;
  logic          w_push;
  logic          w_pop;
  logic          w_has_data;
  logic          w_baud_last;
  logic          w_parity;

  assign w_push      = TX_VALID && (r_count != CNT_FULL);
  assign w_has_data  = (r_count != '0);
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_parity    = (^r_shift) ^ (PARITY_ODD != 0);

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud + BAUD_ONE;
    w_bit_next   = r_bit;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (w_has_data) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_state_next = S_DATA;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_bit_next   = '0;
            w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_baud_last) begin
          w_state_next = S_STOP;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit == STOP_LAST) begin
            w_bit_next = '0;
            // Back-to-back frames: the next byte is popped on the last stop
            // cycle so its start bit follows with no idle gap.
            if (w_has_data) begin
              w_pop        = 1'b1;
              w_state_next = S_START;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
        w_bit_next   = '0;
      end
    endcase
  end

  assign w_shift_next = w_pop ? r_mem[r_rd_ptr] : r_shift;

  // Line value is computed from the next state and registered, so UART_TX
  // changes exactly on the bit boundary edge and never glitches.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[w_bit_next];
      S_PARITY: w_tx_next = w_parity;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Storage needs no reset; clearing the pointers discards the contents.
  always_ff @(posedge sysclk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= TX_DATA;
    end
  end

  assign TX_READY   = (r_count != CNT_FULL);
  assign UART_TX    = r_tx;
  assign TX_BUSY    = r_busy;
  assign FIFO_COUNT = r_count;

endmodule
